// File: rtl/stream_mux2to1.sv
// rtl/stream_mux2to1.sv - two-input round-robin stream merger with registered output
// A single output register stage accepts at most one input beat per cycle.
module stream_mux2to1 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sel;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_load_en;
  logic w_grant0;
  logic w_grant1;

  assign w_load_en = ~r_out_valid | out_ready;

  // rst_n gating keeps both readys low for the whole reset window
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rst_n && w_load_en) begin
      if (in0_valid && in1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = in0_valid;
        w_grant1 = in1_valid;
      end
    end
  end

  assign in0_ready = w_grant0;
  assign in1_ready = w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= in0_data;
      r_out_sel    <= 1'b0;
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= in1_data;
      r_out_sel    <= 1'b1;
      r_last_grant <= 1'b1;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturating per-channel accept counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_grant1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule
